dp_dispatch: RTL and testbench

DP_DISPATCH -- requirements
Module: dp_dispatch

---
 rtl/dp_dispatch_pkg.sv | 36 +++
 rtl/dp_fifo.sv | 50 +++++
 rtl/dp_dispatch.sv | 142 ++++++++++++++
 tb/tb_dp_dispatch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_dispatch_pkg.sv
// Shared types for the edge-packet dispatcher: packet geometry macros, RS payload struct, FSM states.
`ifndef DP_DISPATCH_DEFS_SVH
`define DP_DISPATCH_DEFS_SVH
`define Packet_size 32
`define Max_replay_Iter 3
`endif

package dp_dispatch_pkg;

  localparam int unsigned PACKET_SIZE     = `Packet_size;
  localparam int unsigned PKT_W           = PACKET_SIZE - 2;
  localparam int unsigned MAX_REPLAY_ITER = `Max_replay_Iter;
  localparam int unsigned RI_W            = $clog2(MAX_REPLAY_ITER);
  localparam int unsigned NE_W            = 16;
  localparam int unsigned MASK_LSB        = 7;
  localparam int unsigned MASK_W          = 3;

  typedef struct packed {
    logic             valid;
    logic [PKT_W-1:0] pkt;
  } DP_task2RS;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ISSUE,
    NEXT_ITER,
    DONE
  } dp_state_e;

  // One-hot replay-iteration tag stamped into each accepted packet.
  function automatic logic [MASK_W-1:0] iter_mask(input logic [RI_W-1:0] iter);
    return MASK_W'(MASK_W'(1) << iter);
  endfunction

endpackage

// File: rtl/dp_fifo.sv
// Synchronous holding FIFO; depth must be a power of two so pointers wrap naturally.
module dp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dp_dispatch.sv
// Edge-packet dispatcher: buffers upstream edges, tags them per replay iteration, issues to the RS.
// Define DP_DISPATCH_PERF_EN to add the stall_cnt performance counter output.
module dp_dispatch
  import dp_dispatch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NE_W-1:0]  num_edges,
  input  logic             edge_valid,
  input  logic [PKT_W-1:0] edge_pkt,
  output logic             edge_ready,
  input  logic             RS_full,
  output logic [RI_W-1:0]  replay_Iter,
  output DP_task2RS        DP_task2RS_out,
  output logic             busy,
  output logic             done
`ifdef DP_DISPATCH_PERF_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  dp_state_e        state_q, state_d;
  logic [NE_W-1:0]  n_q, n_d, acc_q, acc_d, iss_q, iss_d;
  logic [RI_W-1:0]  iter_q, iter_d;
  DP_task2RS        out_q, out_d;
  logic             busy_q, done_q;
  logic             push, pop, fifo_full, fifo_empty;
  logic [PKT_W-1:0] fifo_wdata, fifo_rdata;

  assign edge_ready = ((state_q == FILL) || (state_q == ISSUE)) && !fifo_full && (acc_q < n_q);
  assign push       = edge_valid && edge_ready;
  assign pop        = (state_q == ISSUE) && !fifo_empty && !RS_full;

  always_comb begin
    fifo_wdata = edge_pkt;
    fifo_wdata[MASK_LSB +: MASK_W] = iter_mask(iter_q);
  end

  dp_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PKT_W)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state, counters and registered RS payload.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    acc_d   = acc_q;
    iss_d   = iss_q;
    iter_d  = iter_q;
    out_d   = '0;
    if (push) acc_d = acc_q + NE_W'(1);
    if (pop) begin
      iss_d     = iss_q + NE_W'(1);
      out_d.valid = 1'b1;
      out_d.pkt   = fifo_rdata;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = num_edges;
          acc_d   = '0;
          iss_d   = '0;
          iter_d  = '0;
          state_d = (num_edges == '0) ? DONE : FILL;
        end
      end
      // Move on the accepting cycle so the first packet still pops one cycle later.
      FILL: if (push || !fifo_empty) state_d = ISSUE;
      ISSUE: begin
        if (pop && (iss_d == n_q))
          state_d = (iter_q == RI_W'(MAX_REPLAY_ITER - 1)) ? DONE : NEXT_ITER;
      end
      NEXT_ITER: begin
        iter_d  = iter_q + RI_W'(1);
        acc_d   = '0;
        iss_d   = '0;
        state_d = FILL;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      acc_q   <= '0;
      iss_q   <= '0;
      iter_q  <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      iss_q   <= iss_d;
      iter_q  <= iter_d;
      out_q   <= out_d;
      busy_q  <= (state_d == FILL) || (state_d == ISSUE) || (state_d == NEXT_ITER);
      done_q  <= (state_q == DONE);
    end
  end

  assign replay_Iter    = iter_q;
  assign DP_task2RS_out = out_q;
  assign busy           = busy_q;
  assign done           = done_q;

`ifdef DP_DISPATCH_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles the RS blocks a ready packet.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && start)
      stall_d = '0;
    else if ((state_q == ISSUE) && !fifo_empty && RS_full && (stall_q != '1))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_dp_dispatch.sv
// Directed self-checking bench for dp_dispatch (Max_replay_Iter = 3, FIFO_DEPTH = 4).
module tb_dp_dispatch;
  import dp_dispatch_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [NE_W-1:0]  num_edges = '0;
  logic             edge_valid = 1'b0;
  logic [PKT_W-1:0] edge_pkt = '0;
  logic             RS_full = 1'b0;
  logic             edge_ready, busy, done;
  logic [RI_W-1:0]  replay_Iter;
  DP_task2RS        DP_task2RS_out;
`ifdef DP_DISPATCH_PERF_EN
  logic [31:0]      stall_cnt;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  bit ever_ready = 1'b0;
  logic [PKT_W-1:0] iss_q[$];

  always #5 clk = ~clk;

  dp_dispatch #(.FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .num_edges      (num_edges),
    .edge_valid     (edge_valid),
    .edge_pkt       (edge_pkt),
    .edge_ready     (edge_ready),
    .RS_full        (RS_full),
    .replay_Iter    (replay_Iter),
    .DP_task2RS_out (DP_task2RS_out),
    .busy           (busy),
    .done           (done)
`ifdef DP_DISPATCH_PERF_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  // Collect issued packets, done pulses and any edge_ready activity.
  always @(negedge clk) begin
    if (DP_task2RS_out.valid) iss_q.push_back(DP_task2RS_out.pkt);
    if (done) done_cnt++;
    if (edge_ready) ever_ready = 1'b1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [PKT_W-1:0] raw(input int k);
    return PKT_W'(32'h1234_0380 + k * 32'h0001_0411);
  endfunction

  function automatic logic [PKT_W-1:0] exp_pkt(input logic [PKT_W-1:0] r, input int it);
    logic [PKT_W-1:0] e;
    logic [2:0] m;
    e = r;
    m = 3'(3'b001 << it);
    e[9:7] = m;
    return e;
  endfunction

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; edge_valid = 1'b0; RS_full = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    n_checks++; if (edge_ready !== 1'b0) begin n_fail++; $display("FAIL rst_edge_ready: got %b expected 0", edge_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
    n_checks++; if (DP_task2RS_out !== '0) begin n_fail++; $display("FAIL rst_out: got %h expected 0", DP_task2RS_out); end
    n_checks++; if (replay_Iter !== '0) begin n_fail++; $display("FAIL rst_iter: got %0d expected 0", replay_Iter); end
`ifdef DP_DISPATCH_PERF_EN
    n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_stall: got %0d expected 0", stall_cnt); end
`endif
    reset = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    DP_task2RS e;
    iss_q.delete();
    num_edges = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
    n_checks++; if (edge_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b expected 1", edge_ready); end
    edge_valid = 1'b1; edge_pkt = raw(0);
    tick();
    n_checks++; if (DP_task2RS_out.valid !== 1'b0) begin n_fail++; $display("FAIL basic_early: got %b expected 0", DP_task2RS_out.valid); end
    for (int k = 0; k < 3; k++) begin
      edge_pkt = raw(k + 1);
      if (k == 2) edge_valid = 1'b0;
      else if (k == 1) edge_pkt = raw(2);
      if (k == 0) edge_pkt = raw(1);
      tick();
      e.valid = 1'b1; e.pkt = exp_pkt(raw(k), 0);
      n_checks++; if (DP_task2RS_out !== e) begin n_fail++; $display("FAIL basic_issue%0d: got %h expected %h", k, DP_task2RS_out, e); end
      n_checks++; if (DP_task2RS_out.pkt[9:7] !== 3'b001) begin n_fail++; $display("FAIL basic_mask%0d: got %b expected 001", k, DP_task2RS_out.pkt[9:7]); end
    end
    n_checks++; if (edge_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_end: got %b expected 0", edge_ready); end
    tick();
    n_checks++; if (replay_Iter !== RI_W'(1)) begin n_fail++; $display("FAIL basic_iter: got %0d expected 1", replay_Iter); end
    n_checks++; if (DP_task2RS_out.valid !== 1'b0) begin n_fail++; $display("FAIL basic_gap: got %b expected 0", DP_task2RS_out.valid); end
    num_edges = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (replay_Iter !== RI_W'(1)) begin n_fail++; $display("FAIL basic_start_busy: got iter %0d expected 1", replay_Iter); end
    n_checks++; if (iss_q.size() !== 3) begin n_fail++; $display("FAIL basic_count: got %0d expected 3", iss_q.size()); end
  endtask

  task automatic test_backpressure();
    int acc;
    acc = 0;
    iss_q.delete();
    num_edges = 16'd6; start = 1'b1;
    tick();
    start = 1'b0; RS_full = 1'b1; edge_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      edge_pkt = raw(acc);
      if (edge_ready) acc++;
      tick();
    end
    n_checks++; if (acc !== 4) begin n_fail++; $display("FAIL bp_accepts: got %0d expected 4", acc); end
    n_checks++; if (edge_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b expected 0", edge_ready); end
    n_checks++; if (iss_q.size() !== 0) begin n_fail++; $display("FAIL bp_held: got %0d issues expected 0", iss_q.size()); end
    RS_full = 1'b0;
    for (int c = 0; c < 40 && iss_q.size() < 6; c++) begin
      edge_valid = (acc < 6);
      edge_pkt = raw(acc);
      if (edge_valid && edge_ready) acc++;
      tick();
    end
    edge_valid = 1'b0;
    tick(); tick();
    n_checks++; if (iss_q.size() !== 6) begin n_fail++; $display("FAIL bp_count: got %0d expected 6", iss_q.size()); end
    for (int k = 0; k < iss_q.size(); k++) begin
      n_checks++; if (iss_q[k] !== exp_pkt(raw(k), 0)) begin n_fail++; $display("FAIL bp_order%0d: got %h expected %h", k, iss_q[k], exp_pkt(raw(k), 0)); end
    end
  endtask

  task automatic test_full_pass();
    int acc;
    logic [2:0] masks [6];
    masks = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
    acc = 0; done_cnt = 0;
    iss_q.delete();
    num_edges = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 200 && done_cnt == 0; c++) begin
      edge_valid = 1'b1;
      edge_pkt = raw(acc);
      if (edge_ready) acc++;
      tick();
    end
    edge_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_at_done: got %b expected 0", busy); end
    tick(); tick(); tick();
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL full_done_pulses: got %0d expected 1", done_cnt); end
    n_checks++; if (iss_q.size() !== 6) begin n_fail++; $display("FAIL full_count: got %0d expected 6", iss_q.size()); end
    for (int k = 0; k < iss_q.size() && k < 6; k++) begin
      n_checks++; if (iss_q[k][9:7] !== masks[k]) begin n_fail++; $display("FAIL full_mask%0d: got %b expected %b", k, iss_q[k][9:7], masks[k]); end
      n_checks++; if (iss_q[k] !== exp_pkt(raw(k), k / 2)) begin n_fail++; $display("FAIL full_pkt%0d: got %h expected %h", k, iss_q[k], exp_pkt(raw(k), k / 2)); end
    end
  endtask

  task automatic test_zero();
    done_cnt = 0; ever_ready = 1'b0;
    iss_q.delete();
    num_edges = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_c1: got %b expected 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b expected 0", busy); end
    tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done_c2: got %b expected 1", done); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_c3: got %b expected 0", done); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_pulses: got %0d expected 1", done_cnt); end
    n_checks++; if (iss_q.size() !== 0) begin n_fail++; $display("FAIL zero_issues: got %0d expected 0", iss_q.size()); end
    n_checks++; if (ever_ready !== 1'b0) begin n_fail++; $display("FAIL zero_ready: got %b expected 0", ever_ready); end
  endtask

  task automatic test_reset_mid();
    iss_q.delete();
    num_edges = 16'd4; start = 1'b1;
    tick();
    start = 1'b0; RS_full = 1'b1; edge_valid = 1'b1; edge_pkt = raw(20);
    tick();
    edge_pkt = raw(21);
    tick();
    edge_valid = 1'b0;
    tick();
    n_checks++; if (iss_q.size() !== 0) begin n_fail++; $display("FAIL mid_held: got %0d expected 0", iss_q.size()); end
    reset = 1'b0;
    #1;
    n_checks++; if (DP_task2RS_out !== '0) begin n_fail++; $display("FAIL mid_out: got %h expected 0", DP_task2RS_out); end
    n_checks++; if (edge_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b expected 0", edge_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done: got %b expected 0", done); end
    n_checks++; if (replay_Iter !== '0) begin n_fail++; $display("FAIL mid_iter: got %0d expected 0", replay_Iter); end
    tick();
    reset = 1'b1; RS_full = 1'b0;
    tick();
    n_checks++; if (DP_task2RS_out.valid !== 1'b0) begin n_fail++; $display("FAIL mid_post_release: got %b expected 0", DP_task2RS_out.valid); end
    num_edges = 16'd1; start = 1'b1;
    tick();
    start = 1'b0; edge_valid = 1'b1; edge_pkt = raw(30);
    tick();
    edge_valid = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (iss_q.size() !== 1) begin n_fail++; $display("FAIL mid_new_count: got %0d expected 1", iss_q.size()); end
    n_checks++; if (iss_q.size() > 0 && iss_q[0] !== exp_pkt(raw(30), 0)) begin n_fail++; $display("FAIL mid_new_pkt: got %h expected %h", iss_q[0], exp_pkt(raw(30), 0)); end
  endtask

`ifdef DP_DISPATCH_PERF_EN
  task automatic test_perf();
    num_edges = 16'd2; start = 1'b1;
    tick();
    start = 1'b0; RS_full = 1'b1; edge_valid = 1'b1; edge_pkt = raw(40);
    tick();
    edge_valid = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    RS_full = 1'b0;
    tick();
    n_checks++; if (stall_cnt !== 32'd7) begin n_fail++; $display("FAIL perf_stall: got %0d expected 7", stall_cnt); end
    tick(); tick();
    n_checks++; if (stall_cnt !== 32'd7) begin n_fail++; $display("FAIL perf_stall_hold: got %0d expected 7", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    do_reset();
    test_backpressure();
    do_reset();
    test_full_pass();
    test_zero();
    test_reset_mid();
    do_reset();
`ifdef DP_DISPATCH_PERF_EN
    test_perf();
    do_reset();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
